// File: rtl/mem_copy_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_copy_pkg : state type and default widths shared by mem_copy_engine
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_copy_pkg;

  localparam int c_addr_w = 8;
  localparam int c_data_w = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_copy_engine : byte-wise forward copy over an external registered memory
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Src,
  input  logic [ADDR_W-1:0] Dst,
  input  logic [ADDR_W-1:0] Len,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Count,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Mem_wdata,
  input  logic [DATA_W-1:0] Mem_rdata
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] w_count_inc;

  assign w_count_inc = Count + ADDR_W'(1);

  // The memory output is registered, so write data is forwarded straight
  // from the read port during the WRITE cycle.
  assign ADDR      = MemRead ? r_src_ptr : (MemWrite ? r_dst_ptr : '0);
  assign Mem_wdata = MemWrite ? Mem_rdata : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_src_ptr <= '0;
      r_dst_ptr <= '0;
      r_len     <= '0;
      Count     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            Count <= '0;
            if (Len != '0) begin
              r_src_ptr <= Src;
              r_dst_ptr <= Dst;
              r_len     <= Len;
              Busy      <= 1'b1;
              MemRead   <= 1'b1;
              r_state   <= ST_READ;
            end else begin
              Done    <= 1'b1;
              r_state <= ST_FINISH;
            end
          end
        end
        ST_READ: begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b1;
          r_state  <= ST_WRITE;
        end
        ST_WRITE: begin
          MemWrite  <= 1'b0;
          r_src_ptr <= r_src_ptr + ADDR_W'(1);
          r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
          Count     <= w_count_inc;
          if (w_count_inc == r_len) begin
            Busy    <= 1'b0;
            Done    <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            MemRead <= 1'b1;
            r_state <= ST_READ;
          end
        end
        ST_FINISH: begin
          Done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          Busy     <= 1'b0;
          Done     <= 1'b0;
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_copy_engine : random and directed copies against a byte-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_copy_engine;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Start;
  logic [7:0] Src, Dst, Len;
  logic       Busy, Done, MemRead, MemWrite;
  logic [7:0] Count, ADDR, Mem_wdata, Mem_rdata;

  logic [7:0] mem [256];
  logic       pl_we;
  logic [7:0] pl_addr, pl_data;

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Src(Src), .Dst(Dst), .Len(Len),
    .Busy(Busy), .Done(Done), .Count(Count), .MemRead(MemRead),
    .MemWrite(MemWrite), .ADDR(ADDR), .Mem_wdata(Mem_wdata),
    .Mem_rdata(Mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Environment memory: registered read port, write on strobe, preload port.
  always @(posedge CLK) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (MemWrite) mem[ADDR] <= Mem_wdata;
    if (MemRead && !MemWrite) Mem_rdata <= mem[ADDR];
  end

  typedef struct packed {
    logic       busy, done, rd, wr;
    logic [7:0] addr, count;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_count, ref_rdata;
  bit         chk_en;
  int         checks, errors;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected cycle sequence of one copy, starting at the cycle Start is set up.
  task automatic push_trace(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    exp_t e;
    e = '0; e.count = ref_count; exp_q.push_back(e);
    for (int i = 0; i < int'(l); i++) begin
      e = '0; e.busy = 1; e.rd = 1; e.addr = s + 8'(i); e.count = 8'(i); exp_q.push_back(e);
      e = '0; e.busy = 1; e.wr = 1; e.addr = d + 8'(i); e.count = 8'(i); exp_q.push_back(e);
    end
    e = '0; e.done = 1; e.count = l; exp_q.push_back(e);
  endtask

  task automatic compare_cycle();
    exp_t       e;
    logic [7:0] ew;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin e = '0; e.count = ref_count; end
    ew = 8'h00;
    if (e.rd) ref_rdata = ref_mem[e.addr];
    if (e.wr) begin ew = ref_rdata; ref_mem[e.addr] = ref_rdata; end
    ref_count = e.count;
    check("busy",     int'(Busy),     int'(e.busy));
    check("done",     int'(Done),     int'(e.done));
    check("memread",  int'(MemRead),  int'(e.rd));
    check("memwrite", int'(MemWrite), int'(e.wr));
    check("addr",     int'(ADDR),     int'(e.addr));
    check("count",    int'(Count),    int'(e.count));
    if (!e.rd) check("wdata", int'(Mem_wdata), int'(ew));
    check("strobe_excl", int'(MemRead & MemWrite), 0);
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d; ref_mem[a] = d;
    @(posedge CLK); #1;
    pl_we = 1'b0;
  endtask

  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input bit pulse, output int dcyc);
    Start = 1'b1; Src = s; Dst = d; Len = l;
    push_trace(s, d, l);
    @(posedge CLK); #1;
    Start = 1'b0; Src = 8'($urandom); Dst = 8'($urandom); Len = 8'($urandom);
    dcyc = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge CLK);
      if (pulse && k == 3) begin Start = 1'b1; Src = ~s; Len = 8'd1; end
      if (pulse && k == 4) Start = 1'b0;
      if (Done) begin dcyc = k; break; end
    end
    check("done_cycle", dcyc, 2 * int'(l) + 1);
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;
  endtask

  initial begin
    int dc;
    RST = 1'b1; Start = 1'b0; Src = '0; Dst = '0; Len = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0; Mem_rdata = '0;
    chk_en = 0; checks = 0; errors = 0; ref_count = '0; ref_rdata = '0;

    fork
      forever begin
        @(negedge CLK);
        if (chk_en) compare_cycle();
      end
    join_none

    #12;
    check("rst_busy",  int'(Busy), 0);
    check("rst_count", int'(Count), 0);
    check("rst_strb",  int'({Done, MemRead, MemWrite}), 0);
    @(posedge CLK); #1;
    RST = 1'b0; chk_en = 1;

    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

    // Basic copy
    poke(8'h10, 8'hAA); poke(8'h11, 8'hBB); poke(8'h12, 8'hCC); poke(8'h13, 8'hDD);
    run_copy(8'h10, 8'h80, 8'd4, 1'b0, dc);
    check("basic_done9", dc, 9);
    check("basic_count", int'(Count), 4);
    check("basic_m80", int'(mem[8'h80]), 'hAA);
    check("basic_m83", int'(mem[8'h83]), 'hDD);

    // Zero length
    run_copy(8'h33, 8'h44, 8'd0, 1'b0, dc);
    check("len0_done1", dc, 1);
    check("len0_count", int'(Count), 0);

    // Address wrap
    poke(8'hFE, 8'h5A); poke(8'hFF, 8'hA5); poke(8'h00, 8'h3C);
    run_copy(8'hFE, 8'h01, 8'd3, 1'b0, dc);
    check("wrap_m01", int'(mem[8'h01]), 'h5A);
    check("wrap_m03", int'(mem[8'h03]), 'h3C);

    // Overlap forward
    poke(8'h20, 8'h11); poke(8'h21, 8'h22);
    run_copy(8'h20, 8'h21, 8'd2, 1'b0, dc);
    check("ovl_m21", int'(mem[8'h21]), 'h11);
    check("ovl_m22", int'(mem[8'h22]), 'h11);

    // Start pulse mid-copy is ignored
    run_copy(8'h10, 8'hC0, 8'd4, 1'b1, dc);
    check("pulse_count", int'(Count), 4);

    // Random copies
    for (int n = 0; n < 10; n++) begin
      logic [7:0] l;
      l = 8'($urandom_range(0, 12));
      run_copy(8'($urandom), 8'($urandom), l, (l >= 2) && n[0], dc);
    end

    // Reset in the middle of a copy: async clear, no Done, partial data kept
    Start = 1'b1; Src = 8'h40; Dst = 8'h48; Len = 8'd4;
    push_trace(8'h40, 8'h48, 8'd4);
    @(posedge CLK); #1; Start = 1'b0;
    repeat (3) @(negedge CLK);
    #1; chk_en = 0; RST = 1'b1;
    #1;
    check("arst_busy",  int'(Busy), 0);
    check("arst_strb",  int'({Done, MemRead, MemWrite}), 0);
    check("arst_addr",  int'(ADDR), 0);
    check("arst_wdata", int'(Mem_wdata), 0);
    check("arst_count", int'(Count), 0);
    exp_q.delete(); ref_count = '0;
    repeat (2) begin @(negedge CLK); check("arst_nodone", int'(Done), 0); end
    @(posedge CLK); #1; RST = 1'b0; chk_en = 1;
    repeat (4) @(negedge CLK);
    check("arst_m48", int'(mem[8'h48]), int'(ref_mem[8'h48]));

    // Whole memory image against the model
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("mem_image", bad, 0);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
